modulator_pwm: RTL and testbench

- Downstream consumer of the modulo-N counter (`licznik`); samples its count value and produces a PWM waveform with a programmable duty.
- Duty updates are double-buffered and take effect only at period boundaries, i.e. counter wrap.
- Enable/disable is graceful: the block starts and stops on period boundaries only.

---
 rtl/modulator_pwm_pkg.sv | 20 ++
 rtl/modulator_pwm_wykrywacz_okresu.sv | 28 ++
 rtl/modulator_pwm.sv | 101 ++++++++++
 tb/tb_modulator_pwm.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/modulator_pwm_pkg.sv
// Shared definitions for the PWM modulator: FSM state encodings and the
// saturation limit of the optional period counter.
// Latency: n/a (types and constants only). Backpressure: n/a.
package modulator_pwm_pkg;

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    START  = 2'd1,
    RUN    = 2'd2,
    KONIEC = 2'd3
  } stan_t;

  localparam logic [7:0] OKRESY_MAX = 8'd255;

  // The waveform is driven in RUN and while the last period drains in KONIEC.
  function automatic logic czy_aktywny(input stan_t s);
    return (s == RUN) || (s == KONIEC);
  endfunction

endpackage

// File: rtl/modulator_pwm_wykrywacz_okresu.sv
// Period-start detector for any consumer of a modulo-N counter.
// Latency: combinational wrap from licz; prev_licz registered every clock.
// Backpressure: none.
// Ports: clk, res (async active-low), licz (counter value), wrap (period start).
module wykrywacz_okresu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] licz,
  output logic             wrap
);

  logic [WIDTH-1:0] prev_licz;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      prev_licz <= '0;
    end else begin
      prev_licz <= licz;
    end
  end

  // A counter held at zero gives a single wrap; an upstream reset mid-period
  // looks like a wrap too, which restarts the period cleanly.
  assign wrap = (licz == '0) && (prev_licz != '0);

endmodule

// File: rtl/modulator_pwm.sv
// PWM generator slaved to an external modulo-MODULUS counter, with
// double-buffered duty applied at period start and graceful start/stop.
// Latency: 1 clock from licz to pwm. Backpressure: none (duty writes always accepted).
// Ports: clk, res (async active-low), en (run request), licz (counter value),
//        wyp_wr/wyp (duty write), pwm, okres (period pulse), zajety (shadow
//        pending), aktywny (RUN/KONIEC). With MODULATOR_PWM_LICZNIK_OKRESOW_EN
//        defined, okresy counts okres pulses (saturating, cleared in STOP).
module modulator_pwm
  import modulator_pwm_pkg::*;
#(
  parameter int MODULUS = 12,
  parameter int WIDTH   = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic [WIDTH-1:0] licz,
  input  logic             wyp_wr,
  input  logic [WIDTH:0]   wyp,
  output logic             pwm,
  output logic             okres,
  output logic             zajety,
  output logic             aktywny
`ifdef MODULATOR_PWM_LICZNIK_OKRESOW_EN
  ,
  output logic [7:0]       okresy
`endif
);

  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);

  stan_t          stan, stan_nast;
  logic           wrap;
  logic           biegnie_nast;
  logic [WIDTH:0] wyp_akt, wyp_cien, wyp_obc, wyp_nast;

  wykrywacz_okresu #(.WIDTH(WIDTH)) u_wykrywacz (
    .clk  (clk),
    .res  (res),
    .licz (licz),
    .wrap (wrap)
  );

  always_comb begin
    stan_nast = stan;
    case (stan)
      STOP:    if (en) stan_nast = START;
      START:   if (!en) stan_nast = STOP;
               else if (wrap) stan_nast = RUN;
      RUN:     if (!en) stan_nast = wrap ? STOP : KONIEC;
      KONIEC:  if (en) stan_nast = RUN;
               else if (wrap) stan_nast = STOP;
      default: stan_nast = STOP;
    endcase
  end

  assign wyp_obc      = (wyp > MOD_W) ? MOD_W : wyp;
  // The comparison for the first sample of a period must already use the
  // duty that is being applied at this wrap.
  assign wyp_nast     = wrap ? wyp_cien : wyp_akt;
  assign biegnie_nast = czy_aktywny(stan_nast);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      stan     <= STOP;
      wyp_akt  <= '0;
      wyp_cien <= '0;
      zajety   <= 1'b0;
      pwm      <= 1'b0;
      okres    <= 1'b0;
      aktywny  <= 1'b0;
    end else begin
      stan <= stan_nast;
      if (wrap) wyp_akt <= wyp_cien;
      // A write on the wrap cycle lands in the shadow only; the old shadow
      // is what gets applied, so the new value stays pending.
      if (wyp_wr) begin
        wyp_cien <= wyp_obc;
        zajety   <= 1'b1;
      end else if (wrap) begin
        zajety   <= 1'b0;
      end
      pwm     <= biegnie_nast && ({1'b0, licz} < wyp_nast);
      okres   <= wrap && biegnie_nast;
      aktywny <= biegnie_nast;
    end
  end

`ifdef MODULATOR_PWM_LICZNIK_OKRESOW_EN
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      okresy <= '0;
    end else if (stan_nast == STOP) begin
      okresy <= '0;
    end else if (wrap && biegnie_nast && (okresy != OKRESY_MAX)) begin
      okresy <= okresy + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_modulator_pwm.sv
// Directed bench for modulator_pwm driven by a modulo-12 counter model.
// Each period is observed as 12-bit patterns (bit i = output for licz sample i).
module tb_modulator_pwm;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       en = 1'b0;
  logic [3:0] licz;
  logic       cnt_hold = 1'b0;
  logic       wyp_wr = 1'b0;
  logic [4:0] wyp = 5'd0;
  logic       pwm, okres, zajety, aktywny;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Upstream modulo-12 counter; cnt_hold forces it to 0 like an upstream reset.
  always_ff @(posedge clk or negedge res) begin
    if (!res) licz <= 4'd0;
    else if (cnt_hold) licz <= 4'd0;
    else if (licz == 4'd11) licz <= 4'd0;
    else licz <= licz + 4'd1;
  end

  modulator_pwm #(.MODULUS(12), .WIDTH(4)) dut (
    .clk     (clk),
    .res     (res),
    .en      (en),
    .licz    (licz),
    .wyp_wr  (wyp_wr),
    .wyp     (wyp),
    .pwm     (pwm),
    .okres   (okres),
    .zajety  (zajety),
    .aktywny (aktywny)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Precondition: observed licz == 1, so this cycle shows the outputs for sample 0.
  // en_vec[i] / write at index wi are presented with licz == i+1 (wi=11 -> wrap cycle).
  task automatic run_period(input string tag, input logic [11:0] en_vec,
                            input int wi, input logic [4:0] wv,
                            input logic [11:0] ep, input logic [11:0] eo,
                            input logic [11:0] ez, input logic [11:0] ea);
    logic [11:0] pp, op, zp, ap;
    for (int i = 0; i < 12; i++) begin
      pp[i]  = pwm;
      op[i]  = okres;
      zp[i]  = zajety;
      ap[i]  = aktywny;
      en     = en_vec[i];
      wyp_wr = (i == wi);
      wyp    = wv;
      tick();
    end
    wyp_wr = 1'b0;
    chk({tag, ".pwm"}, 32'(pp), 32'(ep));
    chk({tag, ".okres"}, 32'(op), 32'(eo));
    chk({tag, ".zajety"}, 32'(zp), 32'(ez));
    chk({tag, ".aktywny"}, 32'(ap), 32'(ea));
  endtask

  initial begin
    int n;
    int pulses;
    int hi;
    int ak;

    // Reset state.
    #2 res = 1'b0;
    #1;
    chk("rst.pwm", 32'(pwm), 0);
    chk("rst.okres", 32'(okres), 0);
    chk("rst.zajety", 32'(zajety), 0);
    chk("rst.aktywny", 32'(aktywny), 0);
    tick();
    tick();
    res = 1'b1;

    // Duty write accepted in STOP, then start.
    wyp_wr = 1'b1;
    wyp    = 5'd5;
    tick();
    wyp_wr = 1'b0;
    chk("stop_wr.zajety", 32'(zajety), 1);
    chk("stop_wr.aktywny", 32'(aktywny), 0);
    en = 1'b1;
    n  = 0;
    while (!aktywny && n < 40) begin
      tick();
      n++;
    end
    chk("start.aktywny", 32'(aktywny), 1);
    chk("start.licz", 32'(licz), 1);

    // Basic run and duty extremes / buffering.
    run_period("p1_d5",   12'hFFF, -1, 5'd0,  12'h01F, 12'h001, 12'h000, 12'hFFF);
    run_period("p2_d5",   12'hFFF,  0, 5'd0,  12'h01F, 12'h001, 12'hFFE, 12'hFFF);
    run_period("p3_d0",   12'hFFF,  0, 5'd12, 12'h000, 12'h001, 12'hFFE, 12'hFFF);
    run_period("p4_d12",  12'hFFF,  0, 5'd0,  12'hFFF, 12'h001, 12'hFFE, 12'hFFF);
    run_period("p5_d0",   12'hFFF,  0, 5'd15, 12'h000, 12'h001, 12'hFFE, 12'hFFF);
    run_period("p6_d15",  12'hFFF,  0, 5'd8,  12'hFFF, 12'h001, 12'hFFE, 12'hFFF);
    run_period("p7_d8",   12'hFFF,  3, 5'd3,  12'h0FF, 12'h001, 12'hFF0, 12'hFFF);
    run_period("p8_d3",   12'hFFF,  0, 5'd8,  12'h007, 12'h001, 12'hFFE, 12'hFFF);
    run_period("p9_d8",   12'hFFF, 11, 5'd3,  12'h0FF, 12'h001, 12'h000, 12'hFFF);
    run_period("p10_d8",  12'hFFF, -1, 5'd0,  12'h0FF, 12'h001, 12'hFFF, 12'hFFF);
    run_period("p11_d3",  12'hFFF, -1, 5'd0,  12'h007, 12'h001, 12'h000, 12'hFFF);

    // Upstream reset: counter forced to 0 at licz=7 for 4 cycles.
    n = 0;
    while (licz != 4'd7 && n < 40) begin
      tick();
      n++;
    end
    chk("hold.licz", 32'(licz), 7);
    cnt_hold = 1'b1;
    pulses   = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      pulses += int'(okres);
    end
    cnt_hold = 1'b0;
    tick();
    pulses += int'(okres);
    chk("hold.okres_count", 32'(pulses), 1);
    run_period("h1", 12'hFFF, -1, 5'd0, 12'h007, 12'h000, 12'h000, 12'hFFF);
    run_period("h2", 12'hFFF, -1, 5'd0, 12'h007, 12'h001, 12'h000, 12'hFFF);

    // Graceful stop at licz=2, restart, and cancel while in KONIEC.
    run_period("s1_koniec", 12'h001, -1, 5'd0, 12'h007, 12'h001, 12'h000, 12'hFFF);
    run_period("s2_stop",   12'h000, -1, 5'd0, 12'h000, 12'h000, 12'h000, 12'h000);
    run_period("s3_start",  12'hFFF, -1, 5'd0, 12'h000, 12'h000, 12'h000, 12'h000);
    run_period("s4_run",    12'hFFF, -1, 5'd0, 12'h007, 12'h001, 12'h000, 12'hFFF);
    run_period("s5_cancel", 12'hFE1, -1, 5'd0, 12'h007, 12'h001, 12'h000, 12'hFFF);
    run_period("s6_nogap",  12'hFFF, -1, 5'd0, 12'h007, 12'h001, 12'h000, 12'hFFF);

    // Asynchronous reset mid-RUN with pwm and zajety high.
    wyp_wr = 1'b1;
    wyp    = 5'd5;
    tick();
    wyp_wr = 1'b0;
    chk("pre_rst.pwm", 32'(pwm), 1);
    chk("pre_rst.zajety", 32'(zajety), 1);
    #2 res = 1'b0;
    #1;
    chk("arst.pwm", 32'(pwm), 0);
    chk("arst.okres", 32'(okres), 0);
    chk("arst.zajety", 32'(zajety), 0);
    chk("arst.aktywny", 32'(aktywny), 0);
    #2 en = 1'b0;
    res = 1'b1;
    hi = 0;
    ak = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      hi += int'(pwm);
      ak += int'(aktywny);
    end
    chk("post_rst.pwm_high", 32'(hi), 0);
    chk("post_rst.aktywny", 32'(ak), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
